// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// The generator owns every signal except the pixel enable.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          PIX_EN;
    logic [CW-1:0] SCREEN_X;
    logic [CW-1:0] SCREEN_Y;
    logic          Hs;
    logic          Vs;
    logic          ON_SCREEN;
    logic          VBLANK;
    logic          LINE_START;
    logic          FRAME_START;
    logic [CW-1:0] FETCH_X;
    logic [CW-1:0] FETCH_Y;
    logic          FETCH_ACTIVE;
    logic          BLINK;

    modport master (
        input  PIX_EN,
        output SCREEN_X, SCREEN_Y, Hs, Vs, ON_SCREEN, VBLANK,
               LINE_START, FRAME_START, FETCH_X, FETCH_Y, FETCH_ACTIVE, BLINK
    );

    modport slave (
        output PIX_EN,
        input  SCREEN_X, SCREEN_Y, Hs, Vs, ON_SCREEN, VBLANK,
               LINE_START, FRAME_START, FETCH_X, FETCH_Y, FETCH_ACTIVE, BLINK
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a look-ahead fetch position
// and a frame-rate blink flag. All outputs are registered and pixel-aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int CW           = 11,
    parameter int PREFETCH     = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic            CLK_PIXEL,
    input  logic            RESET,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] FX_INIT  = CW'(PREFETCH);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] x, y, fx, fy;
    logic [CW-1:0] nx, ny, nfx, nfy;
    logic          frame_wrap;
    logic [BW-1:0] blink_cnt;
    logic          blink_q, hs_q, vs_q, on_q, vb_q, ls_q, fs_q, fa_q;

    function automatic logic hs_at(input logic [CW-1:0] px);
        return (px >= HS_FIRST && px <= HS_LAST) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vs_at(input logic [CW-1:0] py);
        return (py >= VS_FIRST && py <= VS_LAST) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic active_at(input logic [CW-1:0] px, input logic [CW-1:0] py);
        return (px < H_ACT) && (py < V_ACT);
    endfunction

    // Both counter pairs share the same raster-order increment, so the fetch
    // pair keeps its fixed lead across line and frame wraps.
    always_comb begin
        nx  = x + CW'(1);
        ny  = y;
        nfx = fx + CW'(1);
        nfy = fy;
        if (x == H_LAST) begin
            nx = '0;
            ny = (y == V_LAST) ? '0 : y + CW'(1);
        end
        if (fx == H_LAST) begin
            nfx = '0;
            nfy = (fy == V_LAST) ? '0 : fy + CW'(1);
        end
        frame_wrap = (x == H_LAST) && (y == V_LAST);
    end

    // Decoded outputs are computed from the next position so they land on the
    // same edge as the counters instead of trailing them by a cycle.
    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            x         <= '0;
            y         <= '0;
            fx        <= FX_INIT;
            fy        <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            hs_q      <= hs_at('0);
            vs_q      <= vs_at('0);
            on_q      <= active_at('0, '0);
            vb_q      <= 1'b0;
            ls_q      <= 1'b1;
            fs_q      <= 1'b1;
            fa_q      <= active_at(FX_INIT, '0);
        end else if (vga.PIX_EN) begin
            x    <= nx;
            y    <= ny;
            fx   <= nfx;
            fy   <= nfy;
            hs_q <= hs_at(nx);
            vs_q <= vs_at(ny);
            on_q <= active_at(nx, ny);
            vb_q <= (ny >= V_ACT);
            ls_q <= (nx == '0);
            fs_q <= (nx == '0) && (ny == '0);
            fa_q <= active_at(nfx, nfy);
            if (frame_wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_q   <= ~blink_q;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    assign vga.SCREEN_X     = x;
    assign vga.SCREEN_Y     = y;
    assign vga.FETCH_X      = fx;
    assign vga.FETCH_Y      = fy;
    assign vga.Hs           = hs_q;
    assign vga.Vs           = vs_q;
    assign vga.ON_SCREEN    = on_q;
    assign vga.VBLANK       = vb_q;
    assign vga.LINE_START   = ls_q;
    assign vga.FRAME_START  = fs_q;
    assign vga.FETCH_ACTIVE = fa_q;
    assign vga.BLINK        = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance plus two tiny
// modes (15x8 raster) that make frame wrap, prefetch, polarity and blink reachable.
module tb_vga_timing_gen;

    logic CLK_PIXEL = 1'b0;
    logic RESET     = 1'b1;
    logic pix_en    = 1'b1;
    int   compared  = 0;
    int   mismatched = 0;
    int   steps     = 0;

    always #5 CLK_PIXEL = ~CLK_PIXEL;

    vga_timing_gen_if #(.CW(11)) if_def ();
    vga_timing_gen_if #(.CW(11)) if_pf ();
    vga_timing_gen_if #(.CW(11)) if_pol ();

    assign if_def.PIX_EN = pix_en;
    assign if_pf.PIX_EN  = pix_en;
    assign if_pol.PIX_EN = pix_en;

    vga_timing_gen u_def (
        .CLK_PIXEL (CLK_PIXEL),
        .RESET     (RESET),
        .vga       (if_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .PREFETCH(3), .BLINK_FRAMES(2)
    ) u_pf (
        .CLK_PIXEL (CLK_PIXEL),
        .RESET     (RESET),
        .vga       (if_pf)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .PREFETCH(0), .BLINK_FRAMES(1)
    ) u_pol (
        .CLK_PIXEL (CLK_PIXEL),
        .RESET     (RESET),
        .vga       (if_pol)
    );

    logic [51:0] obs_def, obs_pf, obs_pol;
    assign obs_def = {if_def.SCREEN_X, if_def.SCREEN_Y, if_def.Hs, if_def.Vs, if_def.ON_SCREEN,
                      if_def.VBLANK, if_def.LINE_START, if_def.FRAME_START, if_def.FETCH_X,
                      if_def.FETCH_Y, if_def.FETCH_ACTIVE, if_def.BLINK};
    assign obs_pf  = {if_pf.SCREEN_X, if_pf.SCREEN_Y, if_pf.Hs, if_pf.Vs, if_pf.ON_SCREEN,
                      if_pf.VBLANK, if_pf.LINE_START, if_pf.FRAME_START, if_pf.FETCH_X,
                      if_pf.FETCH_Y, if_pf.FETCH_ACTIVE, if_pf.BLINK};
    assign obs_pol = {if_pol.SCREEN_X, if_pol.SCREEN_Y, if_pol.Hs, if_pol.Vs, if_pol.ON_SCREEN,
                      if_pol.VBLANK, if_pol.LINE_START, if_pol.FRAME_START, if_pol.FETCH_X,
                      if_pol.FETCH_Y, if_pol.FETCH_ACTIVE, if_pol.BLINK};

    localparam logic [51:0] RST_DEF = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                       11'd0, 11'd0, 1'b1, 1'b0};
    localparam logic [51:0] RST_PF  = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                       11'd3, 11'd0, 1'b1, 1'b0};
    localparam logic [51:0] RST_POL = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                       11'd0, 11'd0, 1'b1, 1'b0};

    // Expected output word after n enabled pixels since reset, derived from
    // absolute position arithmetic rather than stepping counters.
    function automatic logic [51:0] expect_at(int n, int ha, int hfp, int hsy, int hbp,
                                              int va, int vfp, int vsy, int vbp,
                                              bit hp, bit vp, int pf, int bf);
        int ht = ha + hfp + hsy + hbp;
        int vt = va + vfp + vsy + vbp;
        int px = n % ht;
        int py = (n / ht) % vt;
        int fx = (n + pf) % ht;
        int fy = ((n + pf) / ht) % vt;
        int frames = n / (ht * vt);
        logic hs = (px >= ha + hfp && px < ha + hfp + hsy) ? hp : ~hp;
        logic vs = (py >= va + vfp && py < va + vfp + vsy) ? vp : ~vp;
        logic on = (px < ha) && (py < va);
        logic vb = (py >= va);
        logic ls = (px == 0);
        logic fs = (px == 0) && (py == 0);
        logic fa = (fx < ha) && (fy < va);
        logic bl = ((frames / bf) % 2) == 1;
        return {11'(px), 11'(py), hs, vs, on, vb, ls, fs, 11'(fx), 11'(fy), fa, bl};
    endfunction

    function automatic logic [51:0] exp_def(int n);
        return expect_at(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0, 30);
    endfunction

    function automatic logic [51:0] exp_pf(int n);
        return expect_at(n, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 3, 2);
    endfunction

    function automatic logic [51:0] exp_pol(int n);
        return expect_at(n, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 0, 1);
    endfunction

    task automatic tick();
        @(posedge CLK_PIXEL);
        #1;
        if (pix_en) steps++;
    endtask

    task automatic applyReset();
        RESET  = 1'b1;
        pix_en = 1'b1;
        repeat (3) @(posedge CLK_PIXEL);
        #1;
        RESET = 1'b0;
        steps = 0;
    endtask

    task automatic test_reset();
        applyReset();
        compared++;
        if (obs_def !== RST_DEF) begin
            mismatched++;
            $display("[TB] FAIL reset_def: got %h expected %h", obs_def, RST_DEF);
        end
        compared++;
        if (obs_pf !== RST_PF) begin
            mismatched++;
            $display("[TB] FAIL reset_prefetch: got %h expected %h", obs_pf, RST_PF);
        end
        compared++;
        if (obs_pol !== RST_POL) begin
            mismatched++;
            $display("[TB] FAIL reset_polarity: got %h expected %h", obs_pol, RST_POL);
        end
    endtask

    task automatic test_line_wrap();
        int hs_low = 0;
        int first_low = -1;
        int last_low = -1;
        int first_off = -1;
        for (int i = 1; i <= 799; i++) begin
            tick();
            if (if_def.Hs == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(if_def.SCREEN_X);
                last_low = int'(if_def.SCREEN_X);
            end
            if (if_def.ON_SCREEN == 1'b0 && first_off < 0) first_off = int'(if_def.SCREEN_X);
        end
        compared++;
        if ({if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START} !== {11'd799, 11'd0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL line_end_pos: got x=%0d y=%0d ls=%b expected x=799 y=0 ls=0",
                     if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START);
        end
        compared++;
        if (hs_low != 96 || first_low != 656 || last_low != 751) begin
            mismatched++;
            $display("[TB] FAIL hs_window: got count=%0d first=%0d last=%0d expected 96/656/751",
                     hs_low, first_low, last_low);
        end
        compared++;
        if (first_off != 640) begin
            mismatched++;
            $display("[TB] FAIL on_screen_edge: got first off x=%0d expected 640", first_off);
        end
        tick();
        compared++;
        if ({if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START, if_def.FRAME_START}
            !== {11'd0, 11'd1, 1'b1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b expected x=0 y=1 ls=1 fs=0",
                     if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START, if_def.FRAME_START);
        end
    endtask

    task automatic test_pixel_enable();
        for (int k = 0; k < 1600; k++) begin
            pix_en = (k % 2 == 0);
            tick();
            compared++;
            if (obs_def !== exp_def(steps)) begin
                mismatched++;
                $display("[TB] FAIL pix_en_def k=%0d: got %h expected %h", k, obs_def, exp_def(steps));
            end
            compared++;
            if (obs_pf !== exp_pf(steps)) begin
                mismatched++;
                $display("[TB] FAIL pix_en_pf k=%0d: got %h expected %h", k, obs_pf, exp_pf(steps));
            end
            if (k == 1597) begin
                compared++;
                if ({if_def.SCREEN_X, if_def.SCREEN_Y} !== {11'd799, 11'd1}) begin
                    mismatched++;
                    $display("[TB] FAIL line_period_end: got x=%0d y=%0d expected x=799 y=1",
                             if_def.SCREEN_X, if_def.SCREEN_Y);
                end
            end
        end
        compared++;
        if ({if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START} !== {11'd0, 11'd2, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL line_period: got x=%0d y=%0d ls=%b expected x=0 y=2 ls=1",
                     if_def.SCREEN_X, if_def.SCREEN_Y, if_def.LINE_START);
        end
        pix_en = 1'b1;
    endtask

    task automatic test_small_frames();
        int hs_cnt_pf = 0;
        int hs_cnt_pol = 0;
        int vs_cnt_pf = 0;
        int vs_cnt_pol = 0;
        applyReset();
        for (int i = 1; i <= 873; i++) begin
            tick();
            compared++;
            if (obs_pf !== exp_pf(steps)) begin
                mismatched++;
                $display("[TB] FAIL frame_pf n=%0d: got %h expected %h", steps, obs_pf, exp_pf(steps));
            end
            compared++;
            if (obs_pol !== exp_pol(steps)) begin
                mismatched++;
                $display("[TB] FAIL frame_pol n=%0d: got %h expected %h", steps, obs_pol, exp_pol(steps));
            end
            if (steps <= 15) begin
                if (if_pf.Hs == 1'b0) hs_cnt_pf++;
                if (if_pol.Hs == 1'b1) hs_cnt_pol++;
            end
            if (steps < 120) begin
                if (if_pf.Vs == 1'b0) vs_cnt_pf++;
                if (if_pol.Vs == 1'b1) vs_cnt_pol++;
            end
            if (steps == 5) begin
                compared++;
                if ({if_pf.ON_SCREEN, if_pf.FETCH_ACTIVE, if_pf.FETCH_X} !== {1'b1, 1'b0, 11'd8}) begin
                    mismatched++;
                    $display("[TB] FAIL fetch_lead: got on=%b fa=%b fx=%0d expected on=1 fa=0 fx=8",
                             if_pf.ON_SCREEN, if_pf.FETCH_ACTIVE, if_pf.FETCH_X);
                end
            end
            if (steps == 8) begin
                compared++;
                if ({if_pf.ON_SCREEN, if_pol.ON_SCREEN} !== 2'b00) begin
                    mismatched++;
                    $display("[TB] FAIL h_active_edge: got %b%b expected 00",
                             if_pf.ON_SCREEN, if_pol.ON_SCREEN);
                end
            end
            if (steps == 60) begin
                compared++;
                if ({if_pf.ON_SCREEN, if_pf.VBLANK} !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL v_active_edge: got on=%b vb=%b expected on=0 vb=1",
                             if_pf.ON_SCREEN, if_pf.VBLANK);
                end
            end
            if (steps == 117) begin
                compared++;
                if ({if_pf.SCREEN_X, if_pf.SCREEN_Y, if_pf.FETCH_X, if_pf.FETCH_Y, if_pf.FETCH_ACTIVE}
                    !== {11'd12, 11'd7, 11'd0, 11'd0, 1'b1}) begin
                    mismatched++;
                    $display("[TB] FAIL fetch_wrap: got scr=(%0d,%0d) fetch=(%0d,%0d) fa=%b expected (12,7) (0,0) 1",
                             if_pf.SCREEN_X, if_pf.SCREEN_Y, if_pf.FETCH_X, if_pf.FETCH_Y, if_pf.FETCH_ACTIVE);
                end
            end
            if (steps == 120) begin
                compared++;
                if ({if_pf.FRAME_START, if_pf.VBLANK, if_pf.BLINK, if_pol.BLINK} !== 4'b1001) begin
                    mismatched++;
                    $display("[TB] FAIL frame_wrap: got fs=%b vb=%b blink_pf=%b blink_pol=%b expected 1 0 0 1",
                             if_pf.FRAME_START, if_pf.VBLANK, if_pf.BLINK, if_pol.BLINK);
                end
            end
            if (steps == 240) begin
                compared++;
                if ({if_pf.BLINK, if_pol.BLINK} !== 2'b10) begin
                    mismatched++;
                    $display("[TB] FAIL blink_second_frame: got pf=%b pol=%b expected pf=1 pol=0",
                             if_pf.BLINK, if_pol.BLINK);
                end
            end
        end
        compared++;
        if (hs_cnt_pf != 3 || hs_cnt_pol != 3) begin
            mismatched++;
            $display("[TB] FAIL hs_width_small: got pf=%0d pol=%0d expected 3 3", hs_cnt_pf, hs_cnt_pol);
        end
        compared++;
        if (vs_cnt_pf != 30 || vs_cnt_pol != 30) begin
            mismatched++;
            $display("[TB] FAIL vs_width_small: got pf=%0d pol=%0d expected 30 30", vs_cnt_pf, vs_cnt_pol);
        end
    endtask

    task automatic test_reset_mid_frame();
        compared++;
        if ({if_pf.SCREEN_X, if_pf.SCREEN_Y, if_pf.BLINK, if_pol.BLINK} !== {11'd3, 11'd2, 1'b1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_pos: got x=%0d y=%0d blink=%b%b expected x=3 y=2 blink=11",
                     if_pf.SCREEN_X, if_pf.SCREEN_Y, if_pf.BLINK, if_pol.BLINK);
        end
        RESET = 1'b1;
        @(posedge CLK_PIXEL);
        #1;
        compared++;
        if (obs_pf !== RST_PF) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pf: got %h expected %h", obs_pf, RST_PF);
        end
        compared++;
        if (obs_pol !== RST_POL) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pol: got %h expected %h", obs_pol, RST_POL);
        end
        compared++;
        if (obs_def !== RST_DEF) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_def: got %h expected %h", obs_def, RST_DEF);
        end
        RESET = 1'b0;
        steps = 0;
        tick();
        compared++;
        if ({if_pf.SCREEN_X, if_pf.FETCH_X, if_pf.LINE_START} !== {11'd1, 11'd4, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL after_reset_step: got x=%0d fx=%0d ls=%b expected x=1 fx=4 ls=0",
                     if_pf.SCREEN_X, if_pf.FETCH_X, if_pf.LINE_START);
        end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_pixel_enable();
        test_small_frames();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the text-mode GPU. It produces pixel-aligned sync, blanking and position outputs for any mode set by parameters. It also provides a look-ahead fetch position, so the character/font memory pipeline can run PREFETCH pixels ahead of the displayed pixel, and a frame-rate blink flag for cursor and attribute blinking. A pixel-enable input lets the block run from a faster system clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of Hs (0 = active-low)
- VS_POL, 0, asserted level of Vs
- CW, 11, position counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PREFETCH, 0, fetch look-ahead in pixels; 0 ≤ PREFETCH < H_TOTAL
- BLINK_FRAMES, 30, frames per BLINK half-period; must be ≥ 1

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL is the sum of the V_* values (default 525).

Ports:
- CLK_PIXEL  in  1  clock
- RESET  in  1  synchronous, active-high reset
- PIX_EN  in  1  advance one pixel on this edge
- SCREEN_X  out  CW  current pixel column
- SCREEN_Y  out  CW  current line
- Hs  out  1  horizontal sync, level per HS_POL
- Vs  out  1  vertical sync, level per VS_POL
- ON_SCREEN  out  1  current pixel is in the active area
- VBLANK  out  1  SCREEN_Y ≥ V_ACTIVE
- LINE_START  out  1  SCREEN_X == 0
- FRAME_START  out  1  SCREEN_X == 0 and SCREEN_Y == 0
- FETCH_X  out  CW  column PREFETCH pixels ahead
- FETCH_Y  out  CW  line of that look-ahead position
- FETCH_ACTIVE  out  1  look-ahead position is in the active area
- BLINK  out  1  toggles every BLINK_FRAMES frames

## Operation
- **Display counter.** A counter pair (X, Y) scans the raster.
  - On an edge with PIX_EN=1: if X == H_TOTAL-1, then X→0, and Y→(Y == V_TOTAL-1 ? 0 : Y+1). Otherwise X→X+1.
- **Fetch counter.** A second counter pair (FX, FY) uses the same increment and wrap rules. It is held exactly PREFETCH pixels ahead of (X, Y) in raster order, including line and frame wrap.
- **Output alignment.** Every output is a register. All outputs update on the same edge and describe the same position. SCREEN_X/Y, Hs, Vs, ON_SCREEN, VBLANK, LINE_START and FRAME_START always refer to the same pixel. No output lags another by a cycle.
- **Hs** equals HS_POL when X is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Otherwise it equals ~HS_POL.
- **Vs** equals VS_POL when Y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines. Otherwise it equals ~VS_POL.
- **ON_SCREEN** = (X < H_ACTIVE) && (Y < V_ACTIVE).
- **FETCH_ACTIVE** = (FX < H_ACTIVE) && (FY < V_ACTIVE).
- **Blink counter.** It increments on each frame wrap. When it reaches BLINK_FRAMES-1 at a wrap, it clears and BLINK toggles.
- **Holding.** With PIX_EN=0, all state and outputs hold. This includes the pulse outputs: LINE_START and FRAME_START stay high for as long as X==0 is held.
- **Reset.**
  - RESET overrides PIX_EN.
  - State after reset: (X,Y)=(0,0); (FX,FY)=(PREFETCH,0); blink counter 0; BLINK=0.
  - Outputs after reset: SCREEN_X=0, SCREEN_Y=0, Hs=~HS_POL, Vs=~VS_POL, ON_SCREEN=1, VBLANK=0, LINE_START=1, FRAME_START=1, FETCH_X=PREFETCH, FETCH_Y=0, FETCH_ACTIVE=(PREFETCH<H_ACTIVE).
  - RESET asserted mid-frame returns the block to this state on the next edge.

## Timing
- Latency: outputs reflect the new position on the clock edge where PIX_EN=1 is sampled, with no extra pipeline stage.
- At PREFETCH=0: FETCH_* equals SCREEN_X/Y and ON_SCREEN.
- A downstream N-stage pixel pipeline uses PREFETCH=N. It then delays Hs/Vs itself, or consumes FETCH_* and SCREEN_* directly.
- At the frame boundary (H_TOTAL-1, V_TOTAL-1) → (0,0), all of the following occur on the same edge: FRAME_START rises, VBLANK falls, and the blink counter updates (BLINK may toggle).
- Fetch wrap: with (X,Y) = (H_TOTAL-PREFETCH, Y), the fetch position is (0, Y+1), or (0, 0) on the last line.

## Test plan
- **Reset values.** Assert RESET for 3 cycles with PIX_EN=1 → all outputs at the listed reset values. With defaults: Hs=1, Vs=1, ON_SCREEN=1.
- **Line and frame wrap.** Defaults, PIX_EN=1 → after 799 enabled cycles (X,Y)=(799,0). The next edge gives (0,1) with LINE_START=1. After 420000 cycles from reset the position is (0,0) again, with FRAME_START=1.
- **Sync windows.** Defaults → Hs=0 exactly for X=656..751 (96 pixels) on every line. Vs=0 exactly for Y=490..491. ON_SCREEN=0 at X=640 and at Y=480. Repeat with HS_POL=VS_POL=1 → the levels invert.
- **Pixel enable.** PIX_EN toggling 1,0,1,0 → the position advances every other cycle and all outputs hold while PIX_EN=0. The line period is 1600 clocks.
- **Prefetch.** PREFETCH=3 → FETCH_X == (SCREEN_X+3) mod 800 throughout. At SCREEN=(797,524), FETCH=(0,0). FETCH_ACTIVE leads ON_SCREEN by 3 pixels at X=637..639.
- **Blink and reset mid-frame.** BLINK_FRAMES=2 → BLINK toggles at every second frame start. RESET asserted at (300,200) → next edge shows the reset values and BLINK=0.
